// File: rtl/tinyriscv_pkg.sv
// Shared pipeline-control types: sequencer states and hold-source codes.
package tinyriscv_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } pipe_state_e;

  localparam logic [1:0] HOLD_NONE = 2'd0;
  localparam logic [1:0] HOLD_EX   = 2'd1;
  localparam logic [1:0] HOLD_BUS  = 2'd2;
  localparam logic [1:0] HOLD_JTAG = 2'd3;

endpackage

// File: rtl/pipe_hold_perf.sv
// Saturating stall/jump event counters for pipe_hold_ctrl.
module pipe_hold_perf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_inc,
  input  logic        jump_inc,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] jump_cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      jump_cnt_o  <= '0;
    end else begin
      if (stall_inc && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (jump_inc && jump_cnt_o != '1)
        jump_cnt_o <= jump_cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/jump/flush sequencer for PC, IF/ID and ID/EX.
// Define PIPE_HOLD_CTRL_PERF_EN to add stall/jump counters.
module pipe_hold_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int AW           = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          hold_ex_i,
  input  logic          hold_bus_i,
  input  logic          hold_jtag_i,
  output logic          pc_en_o,
  output logic          pc_load_o,
  output logic [AW-1:0] pc_next_o,
  output logic          if_id_en_o,
  output logic          id_ex_en_o,
  output logic          if_id_flush_o,
  output logic          id_ex_flush_o,
  output logic [1:0]    hold_src_o,
  output logic          busy_o
`ifdef PIPE_HOLD_CTRL_PERF_EN
  ,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   jump_cnt_o
`endif
);

  pipe_state_e   state;
  logic [2:0]    flush_cnt;
  logic          pend;
  logic [AW-1:0] pend_addr;

  logic hold_any;
  logic jump_go;
  logic flush_go;

  assign hold_any = hold_jtag_i | hold_bus_i | hold_ex_i;

  // A jump seen in FLUSH comes from a squashed instruction.
  assign jump_go  = !hold_any && state != FLUSH
                  && (jump_req_i || pend);
  assign flush_go = !hold_any && !jump_go
                  && (state == FLUSH
                      || (state == HOLD && flush_cnt != 3'd0));

  assign pc_en_o       = !rst_i && !hold_any;
  assign if_id_en_o    = !rst_i && !hold_any;
  assign id_ex_en_o    = !rst_i && !hold_any;
  assign pc_load_o     = !rst_i && jump_go;
  assign if_id_flush_o = !rst_i && (jump_go || flush_go);
  assign id_ex_flush_o = !rst_i && (jump_go || flush_go);
  assign busy_o        = !rst_i && (state != RUN || pend);

  always_comb begin
    pc_next_o = '0;
    if (pc_load_o)
      pc_next_o = jump_req_i ? jump_addr_i : pend_addr;
  end

  always_comb begin
    hold_src_o = HOLD_NONE;
    if (!rst_i) begin
      unique case (1'b1)
        hold_jtag_i:                 hold_src_o = HOLD_JTAG;
        hold_bus_i && !hold_jtag_i:  hold_src_o = HOLD_BUS;
        hold_ex_i && !hold_bus_i
          && !hold_jtag_i:           hold_src_o = HOLD_EX;
        default:                     hold_src_o = HOLD_NONE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
      pend      <= 1'b0;
      pend_addr <= '0;
    end else if (hold_any) begin
      state <= HOLD;
      if (jump_req_i) begin
        pend      <= 1'b1;
        pend_addr <= jump_addr_i;
      end
    end else if (jump_go) begin
      pend      <= 1'b0;
      flush_cnt <= 3'(FLUSH_CYCLES - 1);
      state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (flush_go) begin
      if (flush_cnt != 3'd0)
        flush_cnt <= flush_cnt - 3'd1;
      state <= (flush_cnt <= 3'd1) ? RUN : FLUSH;
    end else begin
      state <= RUN;
    end
  end

`ifdef PIPE_HOLD_CTRL_PERF_EN
  pipe_hold_perf u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_inc   (hold_any),
    .jump_inc    (jump_go),
    .stall_cnt_o (stall_cnt_o),
    .jump_cnt_o  (jump_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl (FLUSH_CYCLES=3).
// Perf-counter checks compile in with PIPE_HOLD_CTRL_PERF_EN.
module tb_pipe_hold_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        hold_jtag_i;
  logic        pc_en_o;
  logic        pc_load_o;
  logic [31:0] pc_next_o;
  logic        if_id_en_o;
  logic        id_ex_en_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic [1:0]  hold_src_o;
  logic        busy_o;
`ifdef PIPE_HOLD_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] jump_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  pipe_hold_ctrl #(
    .AW           (32),
    .FLUSH_CYCLES (3)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .jump_req_i    (jump_req_i),
    .jump_addr_i   (jump_addr_i),
    .hold_ex_i     (hold_ex_i),
    .hold_bus_i    (hold_bus_i),
    .hold_jtag_i   (hold_jtag_i),
    .pc_en_o       (pc_en_o),
    .pc_load_o     (pc_load_o),
    .pc_next_o     (pc_next_o),
    .if_id_en_o    (if_id_en_o),
    .id_ex_en_o    (id_ex_en_o),
    .if_id_flush_o (if_id_flush_o),
    .id_ex_flush_o (id_ex_flush_o),
    .hold_src_o    (hold_src_o),
    .busy_o        (busy_o)
`ifdef PIPE_HOLD_CTRL_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .jump_cnt_o    (jump_cnt_o)
`endif
  );

  // {pc_en, pc_load, if_id_en, id_ex_en, if_flush, ex_flush, busy, src}
  logic [8:0] obs;
  assign obs = {pc_en_o, pc_load_o, if_id_en_o, id_ex_en_o,
                if_id_flush_o, id_ex_flush_o, busy_o, hold_src_o};

  localparam logic [8:0] V_RUN  = 9'b1_0_1_1_0_0_0_00;
  localparam logic [8:0] V_RUNB = 9'b1_0_1_1_0_0_1_00;
  localparam logic [8:0] V_JMP  = 9'b1_1_1_1_1_1_0_00;
  localparam logic [8:0] V_JMPB = 9'b1_1_1_1_1_1_1_00;
  localparam logic [8:0] V_FLS  = 9'b1_0_1_1_1_1_1_00;

  // Stimulus {jump, hold_ex, hold_bus, hold_jtag}, sampled #1 after negedge.
  task automatic cyc(input logic [3:0] s, input logic [31:0] a);
    @(negedge clk_i);
    {jump_req_i, hold_ex_i, hold_bus_i, hold_jtag_i} = s;
    jump_addr_i = a;
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    cyc(4'b1001, 32'h55);
    tests++;
    if (obs !== 9'b0 || pc_next_o !== 32'h0) begin
      fails++;
      $display("FAIL reset obs=%b pc=%h exp=%b pc=0", obs, pc_next_o, 9'b0);
    end
    cyc(4'b0000, 32'h0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 32'h0);
      tests++;
      if (obs !== V_RUN) begin
        fails++;
        $display("FAIL idle[%0d] obs=%b exp=%b", i, obs, V_RUN);
      end
    end
  endtask

  task automatic test_jump;
    logic [3:0]  s [0:3];
    logic [31:0] a [0:3];
    logic [8:0]  e [0:3];
    s = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
    a = '{32'h100, 32'h999, 32'h0, 32'h0};
    e = '{V_JMP, V_FLS, V_FLS, V_RUN};
    for (int i = 0; i < 4; i++) begin
      cyc(s[i], a[i]);
      tests++;
      if (obs !== e[i] || (e[i][7] && pc_next_o !== 32'h100)) begin
        fails++;
        $display("FAIL jump[%0d] obs=%b pc=%h exp=%b pc=100",
                 i, obs, pc_next_o, e[i]);
      end
    end
  endtask

  task automatic test_hold;
    logic [3:0] s [0:10];
    logic [8:0] e [0:10];
    s = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000,
          4'b0100, 4'b0110, 4'b0010, 4'b0000, 4'b0000};
    e = '{9'b000000_0_11, 9'b000000_1_11, 9'b000000_1_11,
          9'b000000_1_11, V_RUNB, V_RUN,
          9'b000000_0_01, 9'b000000_1_10, 9'b000000_1_10,
          V_RUNB, V_RUN};
    for (int i = 0; i < 11; i++) begin
      cyc(s[i], 32'h0);
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL hold[%0d] obs=%b exp=%b", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_pend;
    logic [3:0]  s [0:6];
    logic [31:0] a [0:6];
    logic [8:0]  e [0:6];
    s = '{4'b1010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    a = '{32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    e = '{9'b000000_0_10, 9'b000000_1_10, 9'b000000_1_10,
          V_JMPB, V_FLS, V_FLS, V_RUN};
    for (int i = 0; i < 7; i++) begin
      cyc(s[i], a[i]);
      tests++;
      if (obs !== e[i] || (e[i][7] && pc_next_o !== 32'h200)) begin
        fails++;
        $display("FAIL pend[%0d] obs=%b pc=%h exp=%b pc=200",
                 i, obs, pc_next_o, e[i]);
      end
    end
  endtask

  task automatic test_pend_overwrite;
    logic [3:0]  s [0:10];
    logic [31:0] a [0:10];
    logic [31:0] p [0:10];
    logic [8:0]  e [0:10];
    s = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
          4'b1010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    a = '{32'h200, 32'h250, 32'h0, 32'h0, 32'h0, 32'h0,
          32'h300, 32'h340, 32'h0, 32'h0, 32'h0};
    p = '{32'h0, 32'h0, 32'h250, 32'h0, 32'h0, 32'h0,
          32'h0, 32'h340, 32'h0, 32'h0, 32'h0};
    e = '{9'b000000_0_10, 9'b000000_1_10, V_JMPB, V_FLS, V_FLS, V_RUN,
          9'b000000_0_10, V_JMPB, V_FLS, V_FLS, V_RUN};
    for (int i = 0; i < 11; i++) begin
      cyc(s[i], a[i]);
      tests++;
      if (obs !== e[i] || (e[i][7] && pc_next_o !== p[i])) begin
        fails++;
        $display("FAIL overwrite[%0d] obs=%b pc=%h exp=%b pc=%h",
                 i, obs, pc_next_o, e[i], p[i]);
      end
    end
  endtask

  task automatic test_flush_hold;
    logic [3:0] s [0:8];
    logic [8:0] e [0:8];
    s = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
          4'b0000, 4'b0000, 4'b0000};
    e = '{V_JMP, 9'b000000_1_01, 9'b000000_1_01, 9'b000000_1_01,
          9'b000000_1_01, 9'b000000_1_01, V_FLS, V_FLS, V_RUN};
    for (int i = 0; i < 9; i++) begin
      cyc(s[i], (i == 0) ? 32'h400 : 32'h0);
      tests++;
      if (obs !== e[i] || (e[i][7] && pc_next_o !== 32'h400)) begin
        fails++;
        $display("FAIL flush_hold[%0d] obs=%b pc=%h exp=%b",
                 i, obs, pc_next_o, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    cyc(4'b1010, 32'h500);
    cyc(4'b0000, 32'h0);
    rst_i = 1'b1;
    #1;
    tests++;
    if (obs !== 9'b0 || pc_next_o !== 32'h0) begin
      fails++;
      $display("FAIL rst_hold obs=%b pc=%h exp=0", obs, pc_next_o);
    end
    cyc(4'b0000, 32'h0);
    rst_i = 1'b0;
    cyc(4'b0000, 32'h0);
    tests++;
    if (obs !== V_RUN) begin
      fails++;
      $display("FAIL rst_pend_drop obs=%b exp=%b", obs, V_RUN);
    end
    cyc(4'b1000, 32'h600);
    cyc(4'b0000, 32'h0);
    rst_i = 1'b1;
    cyc(4'b0000, 32'h0);
    rst_i = 1'b0;
    cyc(4'b0000, 32'h0);
    tests++;
    if (obs !== V_RUN) begin
      fails++;
      $display("FAIL rst_flush_drop obs=%b exp=%b", obs, V_RUN);
    end
  endtask

`ifdef PIPE_HOLD_CTRL_PERF_EN
  task automatic test_perf;
    cyc(4'b0000, 32'h0);
    rst_i = 1'b1;
    cyc(4'b0000, 32'h0);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) cyc(4'b0100, 32'h0);
    for (int k = 0; k < 2; k++) begin
      cyc(4'b1000, 32'h700);
      cyc(4'b0000, 32'h0);
      cyc(4'b0000, 32'h0);
    end
    cyc(4'b0000, 32'h0);
    tests++;
    if (stall_cnt_o !== 32'd10 || jump_cnt_o !== 32'd2) begin
      fails++;
      $display("FAIL perf_cnt stall=%0d jump=%0d exp 10/2",
               stall_cnt_o, jump_cnt_o);
    end
    cyc(4'b1010, 32'h800);
    rst_i = 1'b1;
    cyc(4'b0000, 32'h0);
    rst_i = 1'b0;
    cyc(4'b0000, 32'h0);
    tests++;
    if (stall_cnt_o !== 32'd0 || jump_cnt_o !== 32'd0 || obs !== V_RUN) begin
      fails++;
      $display("FAIL perf_rst stall=%0d jump=%0d obs=%b exp 0/0/%b",
               stall_cnt_o, jump_cnt_o, obs, V_RUN);
    end
  endtask
`endif

  initial begin
    rst_i       = 1'b1;
    jump_req_i  = 1'b0;
    jump_addr_i = 32'h0;
    hold_ex_i   = 1'b0;
    hold_bus_i  = 1'b0;
    hold_jtag_i = 1'b0;
    test_reset();
    test_jump();
    test_hold();
    test_pend();
    test_pend_overwrite();
    test_flush_hold();
    test_reset_mid();
`ifdef PIPE_HOLD_CTRL_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
